// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Bits needed to represent values 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Operand/result bundle between the operand producer and the multiplier.
interface seq_mult_if #(
    parameter int WIDTH = 8
) ();
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   in_1;
    logic [WIDTH-1:0]   in_2;
    logic [2*WIDTH-1:0] out;
    logic               ready;
    logic               done;

    modport master (
        output start, signed_mode, in_1, in_2,
        input  out, ready, done
    );

    modport slave (
        input  start, signed_mode, in_1, in_2,
        output out, ready, done
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencing FSM: accepts a request, counts WIDTH shift-add steps, then one fix-up step.
//   state | meaning
//   IDLE  | ready, waiting for start
//   RUN   | one shift-add step per edge, WIDTH steps
//   FIX   | sign correction and result write, done pulses next cycle
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          ready_o,
    output logic          done_o,
    output logic          accept_o,
    output logic          run_o,
    output logic          fix_o,
    output logic [CW-1:0] step_o
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        accept_o = 1'b0;
        run_o    = 1'b0;
        fix_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept_o = 1'b1;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                run_o = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                fix_o   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign done_o  = done_q;
    assign step_o  = cnt_q;

endmodule

// File: rtl/seq_multiplier.sv
// WIDTH x WIDTH shift-add multiplier, signed or unsigned, WIDTH+1 cycles per product.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    seq_mult_if.slave bus
);

    localparam int CW = clog2(WIDTH + 1);

    logic          accept, run, fix;
    logic [CW-1:0] step;

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               neg_q, neg_d;

    seq_mult_ctrl #(.WIDTH(WIDTH), .CW(CW)) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start_i  (bus.start),
        .ready_o  (bus.ready),
        .done_o   (bus.done),
        .accept_o (accept),
        .run_o    (run),
        .fix_o    (fix),
        .step_o   (step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            neg_q    <= neg_d;
        end
    end

    // Operands are held as magnitudes; the most negative value negates to itself,
    // which read as unsigned is exactly its magnitude.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        out_d    = out_q;
        neg_d    = neg_q;
        if (accept) begin
            mcand_d  = (bus.signed_mode && bus.in_1[WIDTH-1]) ? -bus.in_1 : bus.in_1;
            mplier_d = (bus.signed_mode && bus.in_2[WIDTH-1]) ? -bus.in_2 : bus.in_2;
            neg_d    = bus.signed_mode & (bus.in_1[WIDTH-1] ^ bus.in_2[WIDTH-1]);
            acc_d    = '0;
        end
        if (run) begin
            if (mplier_q[0]) acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << step);
            mplier_d = mplier_q >> 1;
        end
        if (fix) out_d = neg_q ? -acc_q : acc_q;
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed checks of the 8-bit multiplier plus an exhaustive 4-bit sweep in both modes.
module tb_seq_multiplier;
    import seq_mult_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    seq_mult_if #(.WIDTH(8)) if8 ();
    seq_mult_if #(.WIDTH(4)) if4 ();

    seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request, step past the accept edge, then scramble the inputs.
    task automatic accept8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        while (!if8.ready && guard < 40) begin
            tick();
            guard++;
        end
        if8.start       = 1'b1;
        if8.signed_mode = s;
        if8.in_1        = a;
        if8.in_2        = b;
        tick();
        if8.start       = 1'b0;
        if8.signed_mode = ~s;
        if8.in_1        = ~a;
        if8.in_2        = ~b;
    endtask

    // Edges until done is seen; -1 on timeout. Flags any ready=1 before done.
    task automatic wait_done8(output int n, output logic ready_seen);
        n = -1;
        ready_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (if8.ready) ready_seen = 1'b1;
            tick();
            if (if8.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic op8(input string tag, input logic s, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp);
        int   n;
        logic rs;
        accept8(s, a, b);
        wait_done8(n, rs);
        chk({tag, "_lat"}, 32'(n), 32'd9);
        chk({tag, "_busy"}, 32'(rs), 32'd0);
        chk({tag, "_out"}, 32'(if8.out), 32'(exp));
    endtask

    initial begin
        int          n;
        logic        rs;
        logic        seen;
        logic [7:0]  exp4;
        int          sa, sb;

        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        if8.start = 1'b0; if8.signed_mode = 1'b0; if8.in_1 = '0; if8.in_2 = '0;
        if4.start = 1'b0; if4.signed_mode = 1'b0; if4.in_1 = '0; if4.in_2 = '0;
        tick();
        chk("rst_out", 32'(if8.out), 32'd0);
        chk("rst_ready", 32'(if8.ready), 32'd1);
        chk("rst_done", 32'(if8.done), 32'd0);
        // start asserted during reset must be ignored
        if8.start = 1'b1;
        tick();
        chk("rst_start_ready", 32'(if8.ready), 32'd1);
        if8.start = 1'b0;
        rst = 1'b0;
        tick();

        op8("u255x255", 1'b0, 8'd255, 8'd255, 16'hFE01);
        chk("ready_in_done", 32'(if8.ready), 32'd1);
        tick();
        chk("done_one_cycle", 32'(if8.done), 32'd0);
        chk("out_held", 32'(if8.out), 32'h0000FE01);

        op8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("s_m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        op8("s_127xm128", 1'b1, 8'h7F, 8'h80, 16'hC080);
        op8("u_fdx5", 1'b0, 8'hFD, 8'h05, 16'h04F1);
        op8("s_fdx5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        op8("u_zero", 1'b0, 8'h00, 8'hC3, 16'h0000);

        // start pulsed at E3 of a running operation is ignored
        accept8(1'b0, 8'h12, 8'h34);
        tick(); tick();
        if8.start = 1'b1; if8.in_1 = 8'hFF; if8.in_2 = 8'hFF;
        tick();
        if8.start = 1'b0;
        wait_done8(n, rs);
        chk("busy_lat", 32'(n), 32'd6);
        chk("busy_out", 32'(if8.out), 32'h000003A8);

        // back-to-back: start in the done cycle
        chk("b2b_ready", 32'(if8.ready), 32'd1);
        accept8(1'b0, 8'h0B, 8'h0D);
        wait_done8(n, rs);
        chk("b2b_lat", 32'(n), 32'd9);
        chk("b2b_out", 32'(if8.out), 32'h0000008F);

        // reset asserted at E4 aborts the operation
        accept8(1'b1, 8'hFB, 8'h09);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out", 32'(if8.out), 32'd0);
        chk("abort_ready", 32'(if8.ready), 32'd1);
        chk("abort_done", 32'(if8.done), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (if8.done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        op8("post_6x7", 1'b1, 8'd6, 8'd7, 16'h002A);

        // exhaustive 4-bit sweep
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    sa = (s == 1 && a >= 8) ? a - 16 : a;
                    sb = (s == 1 && b >= 8) ? b - 16 : b;
                    exp4 = 8'(sa * sb);
                    if4.start = 1'b1;
                    if4.signed_mode = s[0];
                    if4.in_1 = 4'(a);
                    if4.in_2 = 4'(b);
                    tick();
                    if4.start = 1'b0;
                    n = -1;
                    for (int i = 1; i <= 20; i++) begin
                        tick();
                        if (if4.done) begin
                            n = i;
                            break;
                        end
                    end
                    chk($sformatf("w4_s%0d_%0dx%0d", s, a, b),
                        (n == 5) ? 32'(if4.out) : 32'hDEAD_0000 | 32'(n[15:0]), 32'(exp4));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
